// File: rtl/task_sequencer.sv
// Task sequencer: plays a short micro-program of datapath control words,
// one per clock, selected by a task number latched on start.
module task_sequencer #(
  parameter int          W      = 8,
  parameter logic [7:0]  CONST  = 8'hA3,
  parameter int          LOOP_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [3:0]        task_select,
  input  logic [LOOP_W-1:0] loop_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [2:0]        step_index,
  output logic              MUX0_SELECT,
  output logic              MUX1_SELECT,
  output logic [W-1:0]      MUX0_INP1,
  output logic [W-1:0]      MUX1_INP1,
  output logic [3:0]        ALU_OPERATION_SELECT,
  output logic [4:0]        shamt,
  output logic              write_enable,
  output logic              reset_synchronous,
  output logic [1:0]        combinational_shifter_control,
  output logic [W-1:0]      comp2_mux2_inp_1,
  output logic              op2_mux2_select
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE,
    ERR
  } state_t;

  typedef struct packed {
    logic       m0;
    logic       m1;
    logic [3:0] alu;
    logic [4:0] shamt;
    logic [1:0] csc;
    logic       op2;
    logic       we;
    logic       rs;
  } word_t;

  localparam word_t W_IDLE = '0;
  localparam word_t W_LOAD =
    word_t'{1'b1, 1'b1, 4'd15, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0};
  localparam word_t W_ADD  =
    word_t'{1'b0, 1'b0, 4'd4, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0};
  localparam word_t W_SH3  =
    word_t'{1'b1, 1'b1, 4'd13, 5'd3, 2'b00, 1'b1, 1'b1, 1'b0};
  localparam word_t W_SH4  =
    word_t'{1'b1, 1'b1, 4'd13, 5'd4, 2'b00, 1'b1, 1'b1, 1'b0};
  localparam word_t W_ROT4 =
    word_t'{1'b1, 1'b1, 4'd13, 5'd4, 2'b01, 1'b1, 1'b1, 1'b0};
  localparam word_t W_CLR  =
    word_t'{1'b1, 1'b1, 4'd15, 5'd0, 2'b00, 1'b1, 1'b1, 1'b1};

  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [2:0]        task_q, task_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  word_t             word;
  logic              last;
  logic              first;

  assign first = (step_q == 3'd0);

  always_comb begin
    word = W_IDLE;
    last = 1'b0;
    if (state_q == EXEC) begin
      unique case (task_q)
        3'd0: begin
          word = W_LOAD;
          last = 1'b1;
        end
        3'd1: begin
          word = first ? W_LOAD : W_ADD;
          last = !first;
        end
        3'd2: begin
          word = first ? W_LOAD : W_SH3;
          last = !first;
        end
        3'd3: begin
          word = first ? W_LOAD : W_ADD;
          last = (step_q == 3'd2);
        end
        // loop_q holds the ADD steps still to run, including this one
        3'd4: begin
          word = first ? W_LOAD : W_ADD;
          last = first ? (loop_q == '0)
                       : (loop_q == LOOP_W'(1));
        end
        3'd5: begin
          word = first ? W_LOAD : W_ROT4;
          last = !first;
        end
        3'd6: begin
          word = first ? W_LOAD
               : (step_q == 3'd1) ? W_SH4 : W_ADD;
          last = (step_q == 3'd2);
        end
        3'd7: begin
          word = W_CLR;
          last = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    task_d  = task_q;
    loop_d  = loop_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (task_select[3]) begin
            state_d = ERR;
          end else begin
            state_d = EXEC;
            step_d  = 3'd0;
            task_d  = task_select[2:0];
            loop_d  = loop_count;
          end
        end
      end
      EXEC: begin
        if (abort || last) begin
          state_d = abort ? IDLE : DONE;
          step_d  = 3'd0;
        end else begin
          step_d = (step_q == 3'd7) ? 3'd7 : step_q + 3'd1;
          if (task_q == 3'd4 && !first)
            loop_d = loop_q - LOOP_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      task_q  <= 3'd0;
      loop_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      task_q  <= task_d;
      loop_q  <= loop_d;
    end
  end

  assign busy       = (state_q == EXEC);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);
  assign step_index = step_q;

  assign MUX0_SELECT                   = word.m0;
  assign MUX1_SELECT                   = word.m1;
  assign ALU_OPERATION_SELECT          = word.alu;
  assign shamt                         = word.shamt;
  assign combinational_shifter_control = word.csc;
  assign op2_mux2_select               = word.op2;
  assign write_enable                  = word.we;
  assign reset_synchronous             = word.rs;

  assign MUX0_INP1        = '0;
  assign MUX1_INP1        = W'(CONST);
  assign comp2_mux2_inp_1 = W'(1);

endmodule
